// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared constants for the MAC compute core: datapath widths, FSM and
// control-state encodings, and the field layout of the op_cfg word.
// -----------------------------------------------------------------------------
package core_pkg;

    // Datapath widths
    localparam int LANES       = 16;   // lanes per activation/weight vector
    localparam int LANE_W      = 8;    // int8 lanes
    localparam int ACC_W       = 32;   // dot-product accumulator
    localparam int QPROD_W     = 48;   // requantizer intermediate
    localparam int GBUS_ADDR_W = 19;
    localparam int TOK_W       = 14;   // per-user token counter
    localparam int SLICE_AW    = 3;    // 16-b slice index inside a 128-b row

    // op_cfg layout: {acc_num, quant_scale, quant_bias, quant_shift}
    localparam int OPC_W         = 41;
    localparam int ACC_NUM_W     = 10;
    localparam int SCALE_W       = 10;
    localparam int BIAS_W        = 16;
    localparam int SHIFT_W       = 5;
    localparam int OPC_ACC_LSB   = 31;
    localparam int OPC_SCALE_LSB = 21;
    localparam int OPC_BIAS_LSB  = 5;
    localparam int OPC_SHIFT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_QUANT = 2'd2,
        ST_OUT   = 2'd3
    } core_state_e;

    typedef enum logic [2:0] {
        CS_NONE = 3'd0,
        Q_GEN   = 3'd1,
        K_GEN   = 3'd2,
        V_GEN   = 3'd3,
        ATT_QK  = 3'd4,
        ATT_PV  = 3'd5,
        FFN0    = 3'd6,
        FFN1    = 3'd7
    } ctrl_state_e;

    // A control state launches a job only when it names one of the compute phases.
    function automatic logic is_job_state(input logic [31:0] cs);
        return (cs >= 32'(Q_GEN)) && (cs <= 32'(FFN1));
    endfunction

endpackage

// File: rtl/core_mac_quant.sv
// -----------------------------------------------------------------------------
// core_mac_quant
// 16-lane signed int8 dot product, 32-b accumulator and int8 requantizer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   acc_clr           zero the accumulator (job entry)
//   acc_en            add this cycle's dot product into the accumulator
//   act, wrow         activation vector and weight row (lane i at [8i+7:8i])
//   quant_scale/bias/shift, rc_scale   requantization parameters
//   result            int8 requantized accumulator (combinational)
// -----------------------------------------------------------------------------
module core_mac_quant
    import core_pkg::*;
#(
    parameter int NUM_LANES = LANES,
    parameter int DATA_W    = LANE_W,
    parameter int COEF_W    = LANE_W,
    parameter int RC_W      = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acc_clr,
    input  logic                          acc_en,
    input  logic [NUM_LANES*DATA_W-1:0]   act,
    input  logic [NUM_LANES*COEF_W-1:0]   wrow,
    input  logic [SCALE_W-1:0]            quant_scale,
    input  logic signed [BIAS_W-1:0]      quant_bias,
    input  logic [SHIFT_W-1:0]            quant_shift,
    input  logic [RC_W-1:0]               rc_scale,
    output logic signed [7:0]             result
);

    function automatic logic signed [DATA_W+COEF_W-1:0] lane_mul(
        input logic signed [DATA_W-1:0] a,
        input logic signed [COEF_W-1:0] b
    );
        return a * b;
    endfunction

    // r = acc * rc_eff * scale + bias, then arithmetic right shift.
    // A zero recompute scale means "no rescaling", so it acts as 1.
    function automatic logic signed [QPROD_W-1:0] requant(
        input logic signed [ACC_W-1:0]  acc,
        input logic [RC_W-1:0]          rc,
        input logic [SCALE_W-1:0]       scale,
        input logic signed [BIAS_W-1:0] bias,
        input logic [SHIFT_W-1:0]       shift
    );
        logic signed [QPROD_W-1:0] acc_x;
        logic signed [QPROD_W-1:0] rc_x;
        logic signed [QPROD_W-1:0] sc_x;
        logic signed [QPROD_W-1:0] b_x;
        logic signed [QPROD_W-1:0] r;
        acc_x = QPROD_W'(acc);
        rc_x  = (rc == '0) ? QPROD_W'(1) : QPROD_W'(rc);
        sc_x  = QPROD_W'(scale);
        b_x   = QPROD_W'(bias);
        r     = acc_x * rc_x * sc_x + b_x;
        return r >>> shift;
    endfunction

    function automatic logic signed [7:0] sat_int8(input logic signed [QPROD_W-1:0] v);
        if (v > 48'sd127)
            return 8'sh7f;
        else if (v < -48'sd128)
            return 8'sh80;
        else
            return v[7:0];
    endfunction

    logic signed [ACC_W-1:0] dot_p0;
    logic signed [ACC_W-1:0] acc_p1;

    // Stage p0: combinational 16-lane dot product of the current row
    always_comb begin
        dot_p0 = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            dot_p0 = dot_p0 + ACC_W'(lane_mul(act[i*DATA_W +: DATA_W],
                                              wrow[i*COEF_W +: COEF_W]));
        end
    end

    // Stage p1: accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_p1 <= '0;
        else if (acc_clr)
            acc_p1 <= '0;
        else if (acc_en)
            acc_p1 <= acc_p1 + dot_p0;
    end

    // Requantized result, sampled by the top in its QUANT cycle
    assign result = sat_int8(requant(acc_p1, rc_scale, quant_scale, quant_bias, quant_shift));

endmodule

// File: rtl/mac_core_top.sv
// -----------------------------------------------------------------------------
// mac_core_top
// One compute core: 16x128-b weight buffer, latched int8 activation vector,
// and a job FSM (IDLE -> RUN x acc_num -> QUANT -> OUT) that produces one
// requantized int8 result per trigger on the global bus.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   core_mem_*                     16-b slice access to the weight buffer
//   in_gbus_*                      full weight-row write
//   out_gbus_*                     result write (single-cycle wen pulse)
//   *_cfg / *_cfg_vld              configuration registers
//   control_state(_update), start  job trigger; finish pulses with the result
//   rc_scale*                      recompute scale register
//   clean_kv_cache*                per-user token counter clear
//   vlink_*                        activation input and 1-cycle echo
//   hlink_*                        horizontal link register
// -----------------------------------------------------------------------------
module mac_core_top
    import core_pkg::*;
#(
    parameter int MAC_MULT_NUM          = 16,
    parameter int IDATA_WIDTH           = 8,
    parameter int WMEM_DEPTH            = 16,
    parameter int CORE_MEM_ADDR_WIDTH   = 7,
    parameter int INTERFACE_DATA_WIDTH  = 16,
    parameter int USER_ID_WIDTH         = 2,
    parameter int RECOMPUTE_SCALE_WIDTH = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CORE_MEM_ADDR_WIDTH-1:0]        core_mem_addr,
    input  logic [INTERFACE_DATA_WIDTH-1:0]       core_mem_wdata,
    input  logic                                  core_mem_wen,
    input  logic                                  core_mem_ren,
    output logic [INTERFACE_DATA_WIDTH-1:0]       core_mem_rdata,
    output logic                                  core_mem_rvld,
    input  logic [GBUS_ADDR_W-1:0]                in_gbus_addr,
    input  logic                                  in_gbus_wen,
    input  logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   in_gbus_wdata,
    output logic [GBUS_ADDR_W-1:0]                out_gbus_addr,
    output logic                                  out_gbus_wen,
    output logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   out_gbus_wdata,
    input  logic                                  op_cfg_vld,
    input  logic [OPC_W-1:0]                      op_cfg,
    input  logic                                  usr_cfg_vld,
    input  logic [11:0]                           usr_cfg,
    input  logic                                  model_cfg_vld,
    input  logic [29:0]                           model_cfg,
    input  logic                                  pmu_cfg_vld,
    input  logic [3:0]                            pmu_cfg,
    input  logic                                  rc_cfg_vld,
    input  logic [83:0]                           rc_cfg,
    input  logic [31:0]                           control_state,
    input  logic                                  control_state_update,
    input  logic                                  start,
    output logic                                  finish,
    input  logic [RECOMPUTE_SCALE_WIDTH-1:0]      rc_scale,
    input  logic                                  rc_scale_vld,
    input  logic                                  rc_scale_clear,
    input  logic                                  clean_kv_cache,
    input  logic [USER_ID_WIDTH-1:0]              clean_kv_cache_user_id,
    input  logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   vlink_data_in,
    input  logic                                  vlink_data_in_vld,
    output logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   vlink_data_out,
    output logic                                  vlink_data_out_vld,
    input  logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   hlink_wdata,
    input  logic                                  hlink_wen,
    output logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   hlink_rdata,
    output logic                                  hlink_rvalid
);

    localparam int VEC_W  = MAC_MULT_NUM * IDATA_WIDTH;
    localparam int ROW_AW = $clog2(WMEM_DEPTH);
    localparam int NUSERS = 1 << USER_ID_WIDTH;

    logic [VEC_W-1:0]                 wmem [WMEM_DEPTH];
    logic [VEC_W-1:0]                 act_reg;
    logic [OPC_W-1:0]                 op_cfg_reg;
    logic [11:0]                      usr_cfg_reg;
    logic [29:0]                      model_cfg_reg;
    logic [3:0]                       pmu_cfg_reg;
    logic [83:0]                      rc_cfg_reg;
    logic [31:0]                      control_state_reg;
    logic [RECOMPUTE_SCALE_WIDTH-1:0] rc_reg;

    core_state_e                      state;
    logic [ACC_NUM_W-1:0]             beat;
    logic [ACC_NUM_W-1:0]             beat_last;
    logic [USER_ID_WIDTH-1:0]         job_user;
    logic [TOK_W-1:0]                 tok_cnt [NUSERS];

    logic                             trigger;
    logic [ACC_NUM_W-1:0]             acc_num;
    logic signed [7:0]                q_result;

    logic [ROW_AW-1:0]                cm_row;
    logic [SLICE_AW-1:0]              cm_slice;

    assign cm_slice = core_mem_addr[SLICE_AW-1:0];
    assign cm_row   = core_mem_addr[CORE_MEM_ADDR_WIDTH-1:SLICE_AW];
    assign acc_num  = op_cfg_reg[OPC_ACC_LSB +: ACC_NUM_W];

    // Busy cores ignore triggers; an update is judged on the incoming value.
    assign trigger = (state == ST_IDLE) &&
                     ((control_state_update && is_job_state(control_state)) ||
                      (start && is_job_state(control_state_reg)));

    // Configuration, link and scale registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cfg_reg         <= '0;
            usr_cfg_reg        <= '0;
            model_cfg_reg      <= '0;
            pmu_cfg_reg        <= '0;
            rc_cfg_reg         <= '0;
            control_state_reg  <= '0;
            rc_reg             <= '0;
            act_reg            <= '0;
            vlink_data_out     <= '0;
            vlink_data_out_vld <= 1'b0;
            hlink_rdata        <= '0;
            hlink_rvalid       <= 1'b0;
        end else begin
            if (op_cfg_vld)           op_cfg_reg        <= op_cfg;
            if (usr_cfg_vld)          usr_cfg_reg       <= usr_cfg;
            if (model_cfg_vld)        model_cfg_reg     <= model_cfg;
            if (pmu_cfg_vld)          pmu_cfg_reg       <= pmu_cfg;
            if (rc_cfg_vld)           rc_cfg_reg        <= rc_cfg;
            if (control_state_update) control_state_reg <= control_state;
            if (rc_scale_clear)
                rc_reg <= '0;
            else if (rc_scale_vld)
                rc_reg <= rc_scale;
            if (vlink_data_in_vld)    act_reg           <= vlink_data_in;
            vlink_data_out     <= vlink_data_in;
            vlink_data_out_vld <= vlink_data_in_vld;
            if (hlink_wen)            hlink_rdata       <= hlink_wdata;
            hlink_rvalid       <= hlink_wen;
        end
    end

    // Weight buffer: the slice write is issued last so it overrides its 16 b
    // of a same-cycle full-row write to the same row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < WMEM_DEPTH; r++)
                wmem[r] <= '0;
            core_mem_rdata <= '0;
            core_mem_rvld  <= 1'b0;
        end else begin
            if (in_gbus_wen)
                wmem[in_gbus_addr[ROW_AW-1:0]] <= in_gbus_wdata;
            if (core_mem_wen)
                wmem[cm_row][cm_slice*INTERFACE_DATA_WIDTH +: INTERFACE_DATA_WIDTH] <= core_mem_wdata;
            if (core_mem_ren)
                core_mem_rdata <= wmem[cm_row][cm_slice*INTERFACE_DATA_WIDTH +: INTERFACE_DATA_WIDTH];
            core_mem_rvld <= core_mem_ren;
        end
    end

    // Job FSM with registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            beat           <= '0;
            beat_last      <= '0;
            job_user       <= '0;
            out_gbus_wen   <= 1'b0;
            out_gbus_addr  <= '0;
            out_gbus_wdata <= '0;
            finish         <= 1'b0;
            for (int u = 0; u < NUSERS; u++)
                tok_cnt[u] <= '0;
        end else begin
            out_gbus_wen <= 1'b0;
            finish       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state     <= ST_RUN;
                        beat      <= '0;
                        beat_last <= (acc_num == '0) ? '0 : acc_num - 1'b1;
                        job_user  <= usr_cfg_reg[USER_ID_WIDTH-1:0];
                    end
                end
                ST_RUN: begin
                    if (beat == beat_last)
                        state <= ST_QUANT;
                    else
                        beat <= beat + 1'b1;
                end
                ST_QUANT: begin
                    out_gbus_wen   <= 1'b1;
                    finish         <= 1'b1;
                    out_gbus_wdata <= {{(VEC_W-8){1'b0}}, q_result};
                    out_gbus_addr  <= {control_state_reg[2:0], job_user, tok_cnt[job_user]};
                    state          <= ST_OUT;
                end
                ST_OUT: begin
                    tok_cnt[job_user] <= tok_cnt[job_user] + TOK_W'(1);
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // Issued after the increment so a coinciding clear wins.
            if (clean_kv_cache)
                tok_cnt[clean_kv_cache_user_id] <= '0;
        end
    end

    core_mac_quant #(
        .NUM_LANES (MAC_MULT_NUM),
        .DATA_W    (IDATA_WIDTH),
        .COEF_W    (IDATA_WIDTH),
        .RC_W      (RECOMPUTE_SCALE_WIDTH)
    ) u_mac_quant (
        .clk         (clk),
        .rst         (rst),
        .acc_clr     (trigger),
        .acc_en      (state == ST_RUN),
        .act         (act_reg),
        .wrow        (wmem[beat[ROW_AW-1:0]]),
        .quant_scale (op_cfg_reg[OPC_SCALE_LSB +: SCALE_W]),
        .quant_bias  (op_cfg_reg[OPC_BIAS_LSB +: BIAS_W]),
        .quant_shift (op_cfg_reg[OPC_SHIFT_LSB +: SHIFT_W]),
        .rc_scale    (rc_reg),
        .result      (q_result)
    );

    // Latched-only configuration and ignored address bits
    logic unused_bits;
    assign unused_bits = ^{in_gbus_addr[GBUS_ADDR_W-1:ROW_AW], usr_cfg_reg[11:USER_ID_WIDTH],
                           model_cfg_reg, pmu_cfg_reg, rc_cfg_reg};

endmodule

// File: tb/tb_mac_core_top.sv
// -----------------------------------------------------------------------------
// tb_mac_core_top
// Directed plus randomized checks of mac_core_top against a behavioural model
// of the job arithmetic (integer dot product over a byte array of weights,
// requantize, saturate) and of the per-user token counters.
// -----------------------------------------------------------------------------
module tb_mac_core_top;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   core_mem_addr;
    logic [15:0]  core_mem_wdata;
    logic         core_mem_wen, core_mem_ren;
    logic [15:0]  core_mem_rdata;
    logic         core_mem_rvld;
    logic [18:0]  in_gbus_addr;
    logic         in_gbus_wen;
    logic [127:0] in_gbus_wdata;
    logic [18:0]  out_gbus_addr;
    logic         out_gbus_wen;
    logic [127:0] out_gbus_wdata;
    logic         op_cfg_vld;
    logic [40:0]  op_cfg;
    logic         usr_cfg_vld;
    logic [11:0]  usr_cfg;
    logic         model_cfg_vld;
    logic [29:0]  model_cfg;
    logic         pmu_cfg_vld;
    logic [3:0]   pmu_cfg;
    logic         rc_cfg_vld;
    logic [83:0]  rc_cfg;
    logic [31:0]  control_state;
    logic         control_state_update, start, finish;
    logic [4:0]   rc_scale;
    logic         rc_scale_vld, rc_scale_clear;
    logic         clean_kv_cache;
    logic [1:0]   clean_kv_cache_user_id;
    logic [127:0] vlink_data_in, vlink_data_out;
    logic         vlink_data_in_vld, vlink_data_out_vld;
    logic [127:0] hlink_wdata, hlink_rdata;
    logic         hlink_wen, hlink_rvalid;

    always #5 clk = ~clk;

    mac_core_top dut (
        .clk(clk), .rst(rst),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .core_mem_wen(core_mem_wen), .core_mem_ren(core_mem_ren),
        .core_mem_rdata(core_mem_rdata), .core_mem_rvld(core_mem_rvld),
        .in_gbus_addr(in_gbus_addr), .in_gbus_wen(in_gbus_wen), .in_gbus_wdata(in_gbus_wdata),
        .out_gbus_addr(out_gbus_addr), .out_gbus_wen(out_gbus_wen), .out_gbus_wdata(out_gbus_wdata),
        .op_cfg_vld(op_cfg_vld), .op_cfg(op_cfg),
        .usr_cfg_vld(usr_cfg_vld), .usr_cfg(usr_cfg),
        .model_cfg_vld(model_cfg_vld), .model_cfg(model_cfg),
        .pmu_cfg_vld(pmu_cfg_vld), .pmu_cfg(pmu_cfg),
        .rc_cfg_vld(rc_cfg_vld), .rc_cfg(rc_cfg),
        .control_state(control_state), .control_state_update(control_state_update),
        .start(start), .finish(finish),
        .rc_scale(rc_scale), .rc_scale_vld(rc_scale_vld), .rc_scale_clear(rc_scale_clear),
        .clean_kv_cache(clean_kv_cache), .clean_kv_cache_user_id(clean_kv_cache_user_id),
        .vlink_data_in(vlink_data_in), .vlink_data_in_vld(vlink_data_in_vld),
        .vlink_data_out(vlink_data_out), .vlink_data_out_vld(vlink_data_out_vld),
        .hlink_wdata(hlink_wdata), .hlink_wen(hlink_wen),
        .hlink_rdata(hlink_rdata), .hlink_rvalid(hlink_rvalid)
    );

    int total = 0;
    int bad   = 0;

    // Reference state
    byte wm [16][16];
    byte actm [16];
    int  rc_m;
    int  tok_m [4];
    int  cs_m;
    int  user_m;
    int  job_user_m;
    int  op_n, op_scale, op_bias, op_shift;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] row_vec(input int r);
        logic [127:0] v;
        for (int l = 0; l < 16; l++) v[l*8 +: 8] = wm[r][l];
        return v;
    endfunction

    function automatic logic [127:0] act_vec();
        logic [127:0] v;
        for (int l = 0; l < 16; l++) v[l*8 +: 8] = actm[l];
        return v;
    endfunction

    // Job result from the arithmetic definition
    function automatic logic [7:0] model_result();
        longint acc = 0;
        longint r;
        int n = (op_n == 0) ? 1 : op_n;
        for (int k = 0; k < n; k++)
            for (int l = 0; l < 16; l++)
                acc += longint'(actm[l]) * longint'(wm[k % 16][l]);
        r = acc * longint'((rc_m == 0) ? 1 : rc_m) * longint'(op_scale) + longint'(op_bias);
        r = r >>> op_shift;
        if (r > 127) return 8'h7f;
        if (r < -128) return 8'h80;
        return 8'(r);
    endfunction

    task automatic gbus_row(input int r);
        in_gbus_addr  = {15'($urandom), 4'(r)};
        in_gbus_wdata = row_vec(r);
        in_gbus_wen   = 1'b1;
        step();
        in_gbus_wen   = 1'b0;
    endtask

    task automatic set_act_const(input byte v);
        for (int l = 0; l < 16; l++) actm[l] = v;
        vlink_data_in     = act_vec();
        vlink_data_in_vld = 1'b1;
        step();
        vlink_data_in_vld = 1'b0;
    endtask

    task automatic set_act_rand();
        for (int l = 0; l < 16; l++) actm[l] = byte'($urandom);
        vlink_data_in     = act_vec();
        vlink_data_in_vld = 1'b1;
        step();
        vlink_data_in_vld = 1'b0;
        vlink_data_in     = 128'($urandom);
    endtask

    task automatic set_op(input int n, input int scale, input int bias, input int shift);
        op_n = n; op_scale = scale; op_bias = bias; op_shift = shift;
        op_cfg     = {10'(n), 10'(scale), 16'(bias), 5'(shift)};
        op_cfg_vld = 1'b1;
        step();
        op_cfg_vld = 1'b0;
    endtask

    task automatic set_rc(input int v, input bit clr);
        rc_scale       = 5'(v);
        rc_scale_vld   = 1'b1;
        rc_scale_clear = clr;
        step();
        rc_scale_vld   = 1'b0;
        rc_scale_clear = 1'b0;
        rc_m = clr ? 0 : v;
    endtask

    task automatic set_user(input int u);
        usr_cfg     = {10'($urandom), 2'(u)};
        usr_cfg_vld = 1'b1;
        step();
        usr_cfg_vld = 1'b0;
        user_m = u;
    endtask

    task automatic trigger_update(input int cs);
        control_state        = 32'(cs);
        control_state_update = 1'b1;
        step();
        control_state_update = 1'b0;
        cs_m = cs;
        job_user_m = user_m;
    endtask

    task automatic trigger_start();
        start = 1'b1;
        step();
        start = 1'b0;
        job_user_m = user_m;
    endtask

    // Called 'pre' cycles after the trigger step; result must appear acc_num+1 steps after it.
    task automatic wait_finish(input string tag, input int pre, input logic [7:0] exp_res);
        int n = (op_n == 0) ? 1 : op_n;
        int cyc = pre;
        logic [18:0] exp_addr;
        while (finish !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        exp_addr = {3'(cs_m), 2'(job_user_m), 14'(tok_m[job_user_m])};
        chk({tag, "_latency"}, 128'(cyc), 128'(n + 1));
        chk({tag, "_wen"},     128'(out_gbus_wen), 128'(1));
        chk({tag, "_data"},    out_gbus_wdata, {120'b0, exp_res});
        chk({tag, "_addr"},    128'(out_gbus_addr), 128'(exp_addr));
    endtask

    task automatic end_job(input string tag, input bit clean_same);
        clean_kv_cache         = clean_same;
        clean_kv_cache_user_id = 2'(job_user_m);
        step();
        clean_kv_cache = 1'b0;
        tok_m[job_user_m] = (tok_m[job_user_m] + 1) % 16384;
        if (clean_same) tok_m[job_user_m] = 0;
        chk({tag, "_finish_pulse"}, 128'({finish, out_gbus_wen}), 128'(0));
    endtask

    task automatic model_reset();
        foreach (wm[r, l]) wm[r][l] = 0;
        foreach (actm[l]) actm[l] = 0;
        foreach (tok_m[u]) tok_m[u] = 0;
        rc_m = 0; cs_m = 0; user_m = 0; job_user_m = 0;
        op_n = 0; op_scale = 0; op_bias = 0; op_shift = 0;
    endtask

    initial begin
        logic [127:0] rv;
        bit           quiet;
        int           n;

        rst = 1'b1;
        core_mem_addr = '0; core_mem_wdata = '0; core_mem_wen = 0; core_mem_ren = 0;
        in_gbus_addr = '0; in_gbus_wen = 0; in_gbus_wdata = '0;
        op_cfg_vld = 0; op_cfg = '0; usr_cfg_vld = 0; usr_cfg = '0;
        model_cfg_vld = 0; model_cfg = '0; pmu_cfg_vld = 0; pmu_cfg = '0;
        rc_cfg_vld = 0; rc_cfg = '0; control_state = '0; control_state_update = 0;
        start = 0; rc_scale = '0; rc_scale_vld = 0; rc_scale_clear = 0;
        clean_kv_cache = 0; clean_kv_cache_user_id = '0;
        vlink_data_in = '0; vlink_data_in_vld = 0; hlink_wdata = '0; hlink_wen = 0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_gbus", {out_gbus_wdata[108:0], out_gbus_addr}, 128'(0));
        chk("rst_pulses", 128'({out_gbus_wen, finish, vlink_data_out_vld, hlink_rvalid, core_mem_rvld}), 128'(0));
        chk("rst_vlink", vlink_data_out, 128'(0));
        chk("rst_hlink", hlink_rdata, 128'(0));

        // core_mem read after reset
        core_mem_addr = 7'h2b; core_mem_ren = 1'b1;
        step();
        core_mem_ren = 1'b0;
        chk("cm_rd_rvld", 128'(core_mem_rvld), 128'(1));
        chk("cm_rd_data", 128'(core_mem_rdata), 128'(0));
        step();
        chk("cm_rvld_pulse", 128'(core_mem_rvld), 128'(0));

        // vlink echo and hlink register
        rv = {$urandom, $urandom, $urandom, $urandom};
        vlink_data_in = rv; vlink_data_in_vld = 1'b1;
        step();
        vlink_data_in_vld = 1'b0;
        chk("vlink_data", vlink_data_out, rv);
        chk("vlink_vld", 128'(vlink_data_out_vld), 128'(1));
        step();
        chk("vlink_vld_drop", 128'(vlink_data_out_vld), 128'(0));
        rv = {$urandom, $urandom, $urandom, $urandom};
        hlink_wdata = rv; hlink_wen = 1'b1;
        step();
        hlink_wen = 1'b0;
        chk("hlink_data", hlink_rdata, rv);
        chk("hlink_rvalid", 128'(hlink_rvalid), 128'(1));
        step();
        chk("hlink_rvalid_drop", 128'(hlink_rvalid), 128'(0));

        // Basic job; a start while busy must be ignored
        for (int l = 0; l < 16; l++) wm[0][l] = 8'h01;
        gbus_row(0);
        set_act_const(8'h10);
        set_op(4, 1, 4, 4);
        trigger_update(1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_finish("job_basic", 1, 8'h10);
        chk("job_basic_addr_lit", 128'(out_gbus_addr), 128'({3'd1, 2'd0, 14'd0}));
        end_job("job_basic", 0);

        // Saturation with rc_scale arriving one cycle after the trigger
        set_op(4, 8, 100, 2);
        trigger_start();
        set_rc(4, 0);
        wait_finish("job_sat", 1, 8'h7f);
        end_job("job_sat", 0);

        // rc clear beats load; zero rc acts as 1
        set_rc(9, 1);
        set_op(1, 1, 0, 8);
        trigger_update(2);
        wait_finish("job_rc_clear", 0, 8'h01);
        end_job("job_rc_clear", 0);
        set_rc(9, 0);
        trigger_start();
        wait_finish("job_rc9", 0, 8'h09);
        end_job("job_rc9", 0);

        // Negative saturation
        set_rc(0, 1);
        set_act_const(8'hf0);
        set_op(1, 1, 0, 0);
        trigger_start();
        wait_finish("job_neg", 0, 8'h80);
        end_job("job_neg", 0);

        // acc_num = 0 behaves as a single beat
        set_act_const(8'h10);
        for (int l = 0; l < 16; l++) wm[1][l] = 8'h02;
        gbus_row(1);
        set_op(0, 1, 0, 4);
        trigger_start();
        wait_finish("job_acc0", 0, 8'h10);
        end_job("job_acc0", 0);

        // Slice write overrides same-cycle row write
        for (int l = 0; l < 16; l++) wm[0][l] = 8'h01;
        wm[0][6] = -1; wm[0][7] = -1;
        in_gbus_addr = 19'd0; in_gbus_wdata = {16{8'h01}}; in_gbus_wen = 1'b1;
        core_mem_addr = {4'd0, 3'd3}; core_mem_wdata = 16'hffff; core_mem_wen = 1'b1;
        step();
        in_gbus_wen = 1'b0; core_mem_wen = 1'b0;
        core_mem_ren = 1'b1;
        step();
        core_mem_ren = 1'b0;
        chk("cm_slice_rd", 128'(core_mem_rdata), 128'(16'hffff));
        set_op(1, 1, 0, 2);
        trigger_start();
        wait_finish("job_slice", 0, 8'h30);
        end_job("job_slice", 0);

        // Token counters: back-to-back, explicit clear, clear coinciding with increment
        set_user(2);
        trigger_start();
        wait_finish("b2b_a", 0, model_result());
        end_job("b2b_a", 0);
        trigger_start();
        wait_finish("b2b_b", 0, model_result());
        end_job("b2b_b", 0);
        clean_kv_cache = 1'b1; clean_kv_cache_user_id = 2'd2;
        step();
        clean_kv_cache = 1'b0;
        tok_m[2] = 0;
        trigger_start();
        wait_finish("after_clean", 0, model_result());
        end_job("after_clean", 1);
        trigger_start();
        wait_finish("clean_wins", 0, model_result());
        end_job("clean_wins", 0);

        // Randomized jobs
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < 16; r++) begin
                for (int l = 0; l < 16; l++) wm[r][l] = byte'($urandom);
                gbus_row(r);
            end
            set_act_rand();
            set_op($urandom_range(0, 20), $urandom_range(0, 1023),
                   int'(shortint'($urandom)), $urandom_range(0, 24));
            set_rc($urandom_range(0, 31), 0);
            set_user($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                trigger_update($urandom_range(1, 7));
            else
                trigger_start();
            wait_finish("rand", 0, model_result());
            end_job("rand", 0);
        end

        // Non-job control state does not trigger, by update or by start
        trigger_update(9);
        start = 1'b1;
        step();
        start = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (finish !== 1'b0) quiet = 1'b0;
            step();
        end
        chk("no_trigger", 128'(quiet), 128'(1));

        // Reset in the middle of a job aborts it
        set_op(8, 1, 0, 0);
        trigger_update(3);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        quiet = 1'b1;
        n = 12;
        for (int i = 0; i < n; i++) begin
            if ({finish, out_gbus_wen} !== 2'b00) quiet = 1'b0;
            step();
        end
        chk("rst_abort", 128'(quiet), 128'(1));
        core_mem_addr = {4'd0, 3'd3}; core_mem_ren = 1'b1;
        step();
        core_mem_ren = 1'b0;
        chk("rst_mem_clear", 128'(core_mem_rdata), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
